reg_mux_sequencer: RTL and testbench

REG_MUX_SEQUENCER -- requirements
Module: reg_mux_sequencer

---
 rtl/reg_mux_sequencer_pkg.sv | 47 ++++
 rtl/reg_mux_sequencer_dwell_counter.sv | 28 ++
 rtl/reg_mux_sequencer.sv | 109 ++++++++++
 tb/tb_reg_mux_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_mux_sequencer_pkg.sv
// Shared types and constants for the register/mux sequencer.
package reg_mux_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHOW_A,
      ST_SHOW_B,
      ST_SHOW_C,
      ST_CLEAR,
      ST_DONE
   } state_t;

   // Select codes for the downstream registered 4:1 mux
   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_C    = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   // Bit positions within src_mask
   localparam int MASK_A = 0;
   localparam int MASK_B = 1;
   localparam int MASK_C = 2;

   // First enabled show phase strictly after 'cur'; CLEAR when none remain
   function automatic state_t next_show(input logic [2:0] mask, input state_t cur);
      state_t nxt;
      nxt = ST_CLEAR;
      case (cur)
         ST_LOAD: begin
            if (mask[MASK_A])      nxt = ST_SHOW_A;
            else if (mask[MASK_B]) nxt = ST_SHOW_B;
            else if (mask[MASK_C]) nxt = ST_SHOW_C;
         end
         ST_SHOW_A: begin
            if (mask[MASK_B])      nxt = ST_SHOW_B;
            else if (mask[MASK_C]) nxt = ST_SHOW_C;
         end
         ST_SHOW_B: begin
            if (mask[MASK_C])      nxt = ST_SHOW_C;
         end
         default: nxt = ST_CLEAR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/reg_mux_sequencer_dwell_counter.sv
// Down-counter timing one show phase: load, decrement, zero flag.
// Decrement stops at zero, so the count never wraps.
module dwell_counter #(
   parameter int W = 4
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load has priority; decrement only while non-zero
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/reg_mux_sequencer.sv
// Sequencer that loads the A/B/C source registers, then steps the output
// mux select through each enabled source for a programmable dwell.
module reg_mux_sequencer
   import reg_mux_sequencer_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               start,
   input  logic [2:0]         src_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               abort,
   output logic               ld_a,
   output logic               ld_b,
   output logic               ld_c,
   output logic [1:0]         output_sel,
   output logic               out_valid,
   output logic [1:0]         out_tag,
   output logic               busy,
   output logic               done
);

   state_t             state, state_nxt;
   logic [2:0]         mask_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] cnt_init;
   logic               in_show, cnt_load, cnt_dec, cnt_zero;
   logic               abortable;

   assign in_show   = (state == ST_SHOW_A) || (state == ST_SHOW_B) || (state == ST_SHOW_C);
   assign abortable = (state == ST_LOAD) || in_show;

   // State register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Capture the sequence configuration only when a start is accepted
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         mask_q  <= '0;
         dwell_q <= '0;
      end else if ((state == ST_IDLE) && start) begin
         mask_q  <= src_mask;
         dwell_q <= dwell;
      end
   end

   // Next-state logic; abort overrides any loading/showing progress
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = (src_mask != 3'b000) ? ST_LOAD : ST_CLEAR;
         ST_LOAD:   state_nxt = next_show(mask_q, ST_LOAD);
         ST_SHOW_A,
         ST_SHOW_B,
         ST_SHOW_C: if (cnt_zero) state_nxt = next_show(mask_q, state);
         ST_CLEAR:  state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (abort && abortable) state_nxt = ST_CLEAR;
   end

   // Moore-style outputs; load enables additionally gated off by abort
   always_comb begin
      output_sel = SEL_ZERO;
      case (state)
         ST_SHOW_A: output_sel = SEL_A;
         ST_SHOW_B: output_sel = SEL_B;
         ST_SHOW_C: output_sel = SEL_C;
         default:   output_sel = SEL_ZERO;
      endcase
      ld_a = (state == ST_LOAD) && mask_q[MASK_A] && !abort;
      ld_b = (state == ST_LOAD) && mask_q[MASK_B] && !abort;
      ld_c = (state == ST_LOAD) && mask_q[MASK_C] && !abort;
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   // Valid/tag track the registered mux, so they lag the select by a cycle
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         out_valid <= 1'b0;
         out_tag   <= 2'b00;
      end else begin
         out_valid <= in_show;
         out_tag   <= output_sel;
      end
   end

   // Counter reloads on entry to each new show phase (dwell 0 behaves as 1)
   assign cnt_init = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
   assign cnt_load = ((state_nxt == ST_SHOW_A) || (state_nxt == ST_SHOW_B) ||
                      (state_nxt == ST_SHOW_C)) && (state_nxt != state);
   assign cnt_dec  = in_show;

   dwell_counter #(.W(DWELL_W)) u_dwell (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .load     (cnt_load),
      .load_val (cnt_init),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

endmodule

// File: tb/tb_reg_mux_sequencer.sv
// Bench: sequencer plus the A/B/C source registers and registered 4:1 mux.
module tb_reg_mux_sequencer;

   logic        Clock, Resetn, start, abort;
   logic [2:0]  src_mask;
   logic [3:0]  dwell;
   logic        ld_a, ld_b, ld_c, out_valid, busy, done;
   logic [1:0]  output_sel, out_tag;
   logic [7:0]  data_a, data_b, reg_a, reg_b;
   logic [15:0] data_c, reg_c, data_out;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [2:0]  ld;
      logic [1:0]  sel;
      logic        ov;
      logic        busy;
      logic        done;
      logic [1:0]  tag;
      logic [15:0] data;
   } obs_t;

   obs_t obs;
   assign obs = {ld_a, ld_b, ld_c, output_sel, out_valid, busy, done, out_tag, data_out};

   reg_mux_sequencer #(.DWELL_W(4)) dut (
      .Clock(Clock), .Resetn(Resetn), .start(start), .src_mask(src_mask),
      .dwell(dwell), .abort(abort), .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c),
      .output_sel(output_sel), .out_valid(out_valid), .out_tag(out_tag),
      .busy(busy), .done(done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Source registers and the registered output mux
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         reg_a <= '0; reg_b <= '0; reg_c <= '0; data_out <= '0;
      end else begin
         if (ld_a) reg_a <= data_a;
         if (ld_b) reg_b <= data_b;
         if (ld_c) reg_c <= data_c;
         case (output_sel)
            2'b00:   data_out <= {8'h00, reg_a};
            2'b01:   data_out <= {8'h00, reg_b};
            2'b10:   data_out <= reg_c;
            default: data_out <= 16'h0000;
         endcase
      end
   end

   function automatic obs_t mk(input logic [2:0] ld, input logic [1:0] sel, input logic ov,
                               input logic b, input logic d, input logic [1:0] tag,
                               input logic [15:0] data);
      return {ld, sel, ov, b, d, tag, data};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      obs_t rst_exp;
      rst_exp = mk(3'b000, 2'b11, 0, 0, 0, 2'b00, 16'h0000);
      Resetn = 1'b0; start = 0; abort = 0; src_mask = 0; dwell = 0;
      data_a = 0; data_b = 0; data_c = 0;
      repeat (2) tick();
      n_tests++;
      if (obs !== rst_exp) begin
         n_fail++; $display("FAIL reset: got %h want %h", obs, rst_exp);
      end
      #2 Resetn = 1'b1;
      tick();
      n_tests++;
      if (obs !== mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000)) begin
         n_fail++; $display("FAIL reset_idle: got %h", obs);
      end
   endtask

   task automatic test_full();
      obs_t exp[$];
      exp = '{mk(3'b111, 2'b11, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b00, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b00, 1, 1, 0, 2'b00, 16'h0012),
              mk(3'b000, 2'b01, 1, 1, 0, 2'b00, 16'h0012),
              mk(3'b000, 2'b01, 1, 1, 0, 2'b01, 16'h0034),
              mk(3'b000, 2'b10, 1, 1, 0, 2'b01, 16'h0034),
              mk(3'b000, 2'b10, 1, 1, 0, 2'b10, 16'hABCD),
              mk(3'b000, 2'b11, 1, 1, 0, 2'b10, 16'hABCD),
              mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000)};
      data_a = 8'h12; data_b = 8'h34; data_c = 16'hABCD;
      src_mask = 3'b111; dwell = 4'd2; start = 1;
      for (int i = 0; i < exp.size(); i++) begin
         tick();
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++; $display("FAIL full c%0d: got %h want %h", i + 1, obs, exp[i]);
         end
         // Config changes mid-sequence must not disturb it
         if (i == 0) begin start = 0; src_mask = 3'b000; dwell = 4'd0; end
      end
   endtask

   task automatic test_mask_ac();
      obs_t exp[$];
      exp = '{mk(3'b101, 2'b11, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b00, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b10, 1, 1, 0, 2'b00, 16'h0056),
              mk(3'b000, 2'b11, 1, 1, 0, 2'b10, 16'h1357),
              mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000)};
      data_a = 8'h56; data_b = 8'hEE; data_c = 16'h1357;
      src_mask = 3'b101; dwell = 4'd0; start = 1;
      for (int i = 0; i < exp.size(); i++) begin
         tick();
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++; $display("FAIL mask101 c%0d: got %h want %h", i + 1, obs, exp[i]);
         end
         if (i == 0) start = 0;
      end
   endtask

   task automatic test_mask_zero();
      obs_t exp[$];
      exp = '{mk(3'b000, 2'b11, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000)};
      src_mask = 3'b000; dwell = 4'd3; start = 1;
      for (int i = 0; i < exp.size(); i++) begin
         tick();
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++; $display("FAIL mask000 c%0d: got %h want %h", i + 1, obs, exp[i]);
         end
         if (i == 0) start = 0;
      end
   endtask

   task automatic test_abort_show();
      obs_t exp[$];
      exp = '{mk(3'b111, 2'b11, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b00, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b00, 1, 1, 0, 2'b00, 16'h0056),
              mk(3'b000, 2'b00, 1, 1, 0, 2'b00, 16'h0056),
              mk(3'b000, 2'b00, 1, 1, 0, 2'b00, 16'h0056),
              mk(3'b000, 2'b01, 1, 1, 0, 2'b00, 16'h0056),
              mk(3'b000, 2'b01, 1, 1, 0, 2'b01, 16'h0034),
              mk(3'b000, 2'b11, 1, 1, 0, 2'b01, 16'h0034),
              mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000)};
      data_a = 8'h56; data_b = 8'h34; data_c = 16'h1357;
      src_mask = 3'b111; dwell = 4'd4; start = 1;
      for (int i = 0; i < exp.size(); i++) begin
         tick();
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++; $display("FAIL abort_b c%0d: got %h want %h", i + 1, obs, exp[i]);
         end
         if (i == 0) start = 0;
         abort = (i == 6);   // second cycle of SHOW_B
      end
      abort = 0;
   endtask

   task automatic test_abort_load();
      obs_t exp[$];
      exp = '{mk(3'b000, 2'b11, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000)};
      src_mask = 3'b111; dwell = 4'd1; start = 1; abort = 1;
      for (int i = 0; i < exp.size(); i++) begin
         tick();
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++; $display("FAIL abort_load c%0d: got %h want %h", i + 1, obs, exp[i]);
         end
         if (i == 0) start = 0;
      end
      abort = 0;
   endtask

   task automatic test_reset_mid();
      obs_t exp[$];
      obs_t rst_exp;
      rst_exp = mk(3'b000, 2'b11, 0, 0, 0, 2'b00, 16'h0000);
      src_mask = 3'b111; dwell = 4'd3; start = 1;
      tick();
      start = 0;
      tick();
      n_tests++;
      if (obs !== mk(3'b000, 2'b00, 0, 1, 0, 2'b11, 16'h0000)) begin
         n_fail++; $display("FAIL rst_mid_show: got %h", obs);
      end
      #2 Resetn = 1'b0;
      #1;
      n_tests++;
      if (obs !== rst_exp) begin
         n_fail++; $display("FAIL rst_mid_now: got %h want %h", obs, rst_exp);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (obs !== rst_exp) begin
            n_fail++; $display("FAIL rst_mid_hold c%0d: got %h want %h", i, obs, rst_exp);
         end
      end
      Resetn = 1'b1;
      src_mask = 3'b010; dwell = 4'd1; data_b = 8'h9A; start = 1;
      exp = '{mk(3'b010, 2'b11, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b01, 0, 1, 0, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 1, 1, 0, 2'b01, 16'h009A),
              mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000),
              mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000)};
      for (int i = 0; i < exp.size(); i++) begin
         tick();
         n_tests++;
         if (obs !== exp[i]) begin
            n_fail++; $display("FAIL rst_restart c%0d: got %h want %h", i + 1, obs, exp[i]);
         end
         if (i == 0) start = 0;
      end
   endtask

   task automatic test_back_to_back();
      obs_t e;
      data_a = 8'h77; src_mask = 3'b001; dwell = 4'd15; start = 1;
      for (int c = 1; c <= 23; c++) begin
         tick();
         if (c == 1 || c == 20)  e = mk(3'b100, 2'b11, 0, 1, 0, 2'b11, 16'h0000);
         else if (c == 2)        e = mk(3'b000, 2'b00, 0, 1, 0, 2'b11, 16'h0000);
         else if (c <= 16)       e = mk(3'b000, 2'b00, 1, 1, 0, 2'b00, 16'h0077);
         else if (c == 17)       e = mk(3'b000, 2'b11, 1, 1, 0, 2'b00, 16'h0077);
         else if (c == 18)       e = mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000);
         else if (c == 19)       e = mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000);
         else if (c == 21)       e = mk(3'b000, 2'b11, 0, 1, 0, 2'b11, 16'h0000);
         else if (c == 22)       e = mk(3'b000, 2'b11, 0, 1, 1, 2'b11, 16'h0000);
         else                    e = mk(3'b000, 2'b11, 0, 0, 0, 2'b11, 16'h0000);
         n_tests++;
         if (obs !== e) begin
            n_fail++; $display("FAIL b2b c%0d: got %h want %h", c, obs, e);
         end
         // Terminate the second run early from its LOAD cycle
         if (c == 20) begin start = 0; abort = 1; end
         if (c == 22) abort = 0;
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_mask_ac();
      test_mask_zero();
      test_abort_show();
      test_abort_load();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
